bus_out_sequencer: RTL and testbench

Sequences a multi-source bus-drive request so that exactly one datapath source drives the shared bus per grant slot. Sits directly upstream of the bus-select priority encoder. It accepts a request vector in which several sources may be flagged at once, then issues one-hot out-enables one source at a time in ascending index order. Bit order matches the encoder inputs: bit0–15 = R0out–R15out, 16 HIout, 17 LOout, 18 Zhighout, 19 Zlowout, 20 PCout, 21 MDRout, 22 In_Portout, 23 Cout.

---
 rtl/bus_out_sequencer.sv | 150 +++++++++++++++
 tb/tb_bus_out_sequencer.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/bus_out_sequencer.sv
// ---------------------------------------------------------------------------
// bus_out_sequencer
//
// Takes a multi-source bus-drive request and grants the shared bus to one
// source at a time, lowest index first, each for HOLD consecutive cycles.
// It feeds the bus-select priority encoder. Bit order of req_vec and out_en:
// 0-15 R0out..R15out, 16 HIout, 17 LOout, 18 Zhighout, 19 Zlowout,
// 20 PCout, 21 MDRout, 22 In_Portout, 23 Cout.
//
// Parameters
//   N_SRC   number of bus sources (<= 31)
//   HOLD    cycles each granted source drives the bus (1..15)
//
// Ports
//   clock    in   system clock, rising edge
//   clear    in   synchronous active-high reset
//   start    in   request strobe, accepted only while ready=1
//   req_vec  in   set of sources to drive
//   abort    in   cancel a sequence in progress (ignored outside GRANT)
//   ready    out  idle, will accept start
//   out_en   out  one-hot (or zero) out-enable to the encoder inputs
//   src_id   out  index of the granted source, 31 when none
//   done     out  one-cycle pulse on normal completion
//
// State table
//   state | meaning
//   IDLE  | waiting for start, ready=1
//   GRANT | lowest pending source drives the bus
//   DONE  | one-cycle completion pulse, then back to IDLE
// ---------------------------------------------------------------------------
module bus_out_sequencer #(
    parameter int N_SRC = 24,
    parameter int HOLD  = 1
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic [N_SRC-1:0] req_vec,
    input  logic             abort,
    output logic             ready,
    output logic [N_SRC-1:0] out_en,
    output logic [4:0]       src_id,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [3:0] HOLD_LAST = 4'(HOLD - 1);
    localparam logic [4:0] NO_SRC    = 5'd31;

    state_t           state_q,    state_d;
    logic [N_SRC-1:0] pending_q,  pending_d;
    logic [3:0]       hold_cnt_q, hold_cnt_d;
    logic             ready_q,    ready_d;
    logic [N_SRC-1:0] out_en_q,   out_en_d;
    logic [4:0]       src_id_q,   src_id_d;
    logic             done_q,     done_d;

    // Isolate the lowest set bit: two's-complement trick.
    function automatic logic [N_SRC-1:0] lowest_bit(input logic [N_SRC-1:0] v);
        return v & (~v + {{(N_SRC-1){1'b0}}, 1'b1});
    endfunction

    function automatic logic [4:0] lowest_idx(input logic [N_SRC-1:0] v);
        logic [4:0] idx;
        idx = NO_SRC;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (v[i]) idx = 5'(i);
        end
        return idx;
    endfunction

    always_comb begin
        state_d    = state_q;
        pending_d  = pending_q;
        hold_cnt_d = hold_cnt_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    pending_d  = req_vec;
                    hold_cnt_d = 4'd0;
                    state_d    = (req_vec != '0) ? GRANT : DONE;
                end
            end
            GRANT: begin
                if (abort) begin
                    state_d    = IDLE;
                    pending_d  = '0;
                    hold_cnt_d = 4'd0;
                end else if (hold_cnt_q == HOLD_LAST) begin
                    pending_d  = pending_q & ~lowest_bit(pending_q);
                    hold_cnt_d = 4'd0;
                    if (pending_d == '0) state_d = DONE;
                end else begin
                    hold_cnt_d = hold_cnt_q + 4'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d    = IDLE;
                pending_d  = '0;
                hold_cnt_d = 4'd0;
            end
        endcase

        // Outputs are registered: decode them from the next state so they
        // line up with the state they describe.
        ready_d  = (state_d == IDLE);
        done_d   = (state_d == DONE);
        out_en_d = '0;
        src_id_d = NO_SRC;
        if (state_d == GRANT) begin
            out_en_d = lowest_bit(pending_d);
            src_id_d = lowest_idx(pending_d);
        end
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            state_q    <= IDLE;
            pending_q  <= '0;
            hold_cnt_q <= 4'd0;
            ready_q    <= 1'b1;
            out_en_q   <= '0;
            src_id_q   <= NO_SRC;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            hold_cnt_q <= hold_cnt_d;
            ready_q    <= ready_d;
            out_en_q   <= out_en_d;
            src_id_q   <= src_id_d;
            done_q     <= done_d;
        end
    end

    assign ready  = ready_q;
    assign out_en = out_en_q;
    assign src_id = src_id_q;
    assign done   = done_q;

endmodule

// File: tb/tb_bus_out_sequencer.sv
// ---------------------------------------------------------------------------
// tb_bus_out_sequencer
//
// Two sequencer instances (HOLD=1 and HOLD=2) share clock, clear, req_vec
// and abort; each has its own start. Expected per-cycle outputs are built
// from the request as a list: each set bit in ascending order occupies HOLD
// cycles, followed by one done cycle and a ready cycle. An abort or clear
// truncates the list to an immediate idle cycle.
// ---------------------------------------------------------------------------
module tb_bus_out_sequencer;

    typedef struct packed {
        logic        ready;
        logic [23:0] oe;
        logic [4:0]  id;
        logic        done;
    } exp_t;

    logic        clock = 1'b0;
    logic        clear = 1'b0;
    logic        start1 = 1'b0;
    logic        start2 = 1'b0;
    logic [23:0] req_vec = '0;
    logic        abort = 1'b0;

    logic        ready1, ready2, done1, done2;
    logic [23:0] out_en1, out_en2;
    logic [4:0]  src_id1, src_id2;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clock = ~clock;

    bus_out_sequencer #(.N_SRC(24), .HOLD(1)) u_h1 (
        .clock   (clock),
        .clear   (clear),
        .start   (start1),
        .req_vec (req_vec),
        .abort   (abort),
        .ready   (ready1),
        .out_en  (out_en1),
        .src_id  (src_id1),
        .done    (done1)
    );

    bus_out_sequencer #(.N_SRC(24), .HOLD(2)) u_h2 (
        .clock   (clock),
        .clear   (clear),
        .start   (start2),
        .req_vec (req_vec),
        .abort   (abort),
        .ready   (ready2),
        .out_en  (out_en2),
        .src_id  (src_id2),
        .done    (done2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_outputs(input bit sel2, input exp_t e, input string tag);
        logic        r, d;
        logic [23:0] oe;
        logic [4:0]  id;
        r  = sel2 ? ready2  : ready1;
        d  = sel2 ? done2   : done1;
        oe = sel2 ? out_en2 : out_en1;
        id = sel2 ? src_id2 : src_id1;
        chk({tag, ".ready"},  32'(r),  32'(e.ready));
        chk({tag, ".out_en"}, 32'(oe), 32'(e.oe));
        chk({tag, ".src_id"}, 32'(id), 32'(e.id));
        chk({tag, ".done"},   32'(d),  32'(e.done));
    endtask

    // One transaction. abort_at>0: abort (or clear) asserted during cycle
    // t+abort_at, so outputs are idle from t+abort_at+1.
    task automatic run_txn(input bit sel2, input logic [23:0] r, input int abort_at,
                           input bit use_clear, input bit noise, input string tag);
        exp_t exp_q[$];
        exp_t e;
        int   hold;
        hold = sel2 ? 2 : 1;
        for (int i = 0; i < 24; i++) begin
            if (r[i]) begin
                for (int h = 0; h < hold; h++) begin
                    e.ready = 1'b0; e.oe = 24'(1) << i; e.id = 5'(i); e.done = 1'b0;
                    exp_q.push_back(e);
                end
            end
        end
        if (abort_at > 0) begin
            while (exp_q.size() > abort_at) void'(exp_q.pop_back());
        end else begin
            e.ready = 1'b0; e.oe = '0; e.id = 5'd31; e.done = 1'b1;
            exp_q.push_back(e);
        end
        e.ready = 1'b1; e.oe = '0; e.id = 5'd31; e.done = 1'b0;
        exp_q.push_back(e);

        @(negedge clock);
        req_vec = r;
        if (sel2) start2 = 1'b1; else start1 = 1'b1;
        for (int c = 1; c <= exp_q.size(); c++) begin
            @(negedge clock);
            chk_outputs(sel2, exp_q[c-1], $sformatf("%s.c%0d", tag, c));
            start1  = 1'b0;
            start2  = 1'b0;
            req_vec = 24'($urandom);
            if (noise && !exp_q[c-1].ready) begin
                if (sel2) start2 = 1'($urandom); else start1 = 1'($urandom);
            end
            abort = (c == abort_at) && !use_clear;
            clear = (c == abort_at) && use_clear;
        end
        start1 = 1'b0; start2 = 1'b0; abort = 1'b0; clear = 1'b0; req_vec = '0;
    endtask

    initial begin
        exp_t idle_e;
        idle_e.ready = 1'b1; idle_e.oe = '0; idle_e.id = 5'd31; idle_e.done = 1'b0;

        // Reset with start and all-ones request held during clear.
        @(negedge clock);
        clear = 1'b1; start1 = 1'b1; start2 = 1'b1; req_vec = '1;
        @(negedge clock);
        chk_outputs(1'b0, idle_e, "rst1.h1");
        chk_outputs(1'b1, idle_e, "rst1.h2");
        @(negedge clock);
        chk_outputs(1'b0, idle_e, "rst2.h1");
        chk_outputs(1'b1, idle_e, "rst2.h2");
        clear = 1'b0; start1 = 1'b0; start2 = 1'b0; req_vec = '0;
        @(negedge clock);
        chk_outputs(1'b0, idle_e, "rst3.h1");
        chk_outputs(1'b1, idle_e, "rst3.h2");

        // Directed cases.
        run_txn(1'b0, 24'h100000, 0, 1'b0, 1'b0, "single_pc");
        run_txn(1'b0, 24'h200006, 0, 1'b0, 1'b1, "multi_h1");
        run_txn(1'b1, 24'h800001, 0, 1'b0, 1'b1, "multi_h2");
        run_txn(1'b0, 24'h00000F, 2, 1'b0, 1'b0, "abort");
        run_txn(1'b0, 24'h00000F, 2, 1'b1, 1'b0, "clear");
        run_txn(1'b1, 24'h00000F, 3, 1'b0, 1'b0, "abort_h2");
        run_txn(1'b0, 24'h000000, 0, 1'b0, 1'b1, "empty_h1");
        run_txn(1'b1, 24'h000000, 0, 1'b0, 1'b0, "empty_h2");
        run_txn(1'b1, 24'hFFFFFF, 0, 1'b0, 1'b1, "all_h2");

        // Abort while idle must be ignored.
        @(negedge clock);
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        chk_outputs(1'b0, idle_e, "abort_idle.h1");

        // Randomised transactions.
        for (int n = 0; n < 24; n++) begin
            logic [23:0] r;
            bit          s2;
            int          k, ab;
            s2 = 1'($urandom);
            case ($urandom_range(0, 3))
                0:       r = 24'($urandom) & 24'($urandom) & 24'($urandom);
                1:       r = 24'(1) << $urandom_range(0, 23);
                default: r = 24'($urandom);
            endcase
            k = $countones(r);
            ab = 0;
            if (k > 0 && $urandom_range(0, 3) == 0)
                ab = $urandom_range(1, k * (s2 ? 2 : 1));
            run_txn(s2, r, ab, 1'($urandom), 1'b1, $sformatf("rnd%0d", n));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
